// File: rtl/contador_cronometro_param_pkg.sv
// Shared constants for the stopwatch/timer counter and its display path.
// Defines the default clock rate, mode encoding and common count widths.
package cronometro_pkg;

  localparam int CLK_HZ_DEF        = 50_000_000;
  localparam int TICKS_PER_SEC_DEF = 10;
  localparam int SEC_MAX_DEF       = 999;
  localparam int SEC_W_DEF         = 10;
  localparam int FRAC_W_DEF        = 4;

  localparam logic MODO_CRESC = 1'b0;
  localparam logic MODO_DESC  = 1'b1;

endpackage

// File: rtl/contador_cronometro_param_if.sv
// Control/status bundle between the control FSM, the counter and the display.
// Lap-capture signals exist only when LAP_CAPTURE_EN is defined.
interface contador_cronometro_param_if #(
  parameter int SEC_W  = 10,
  parameter int FRAC_W = 4
);
  logic              contando;
  logic              modo_desc;
  logic              carga;
  logic [SEC_W-1:0]  carga_seg;
  logic [FRAC_W-1:0] carga_frac;
  logic [SEC_W-1:0]  cont_seg;
  logic [FRAC_W-1:0] cont_frac;
  logic              tick;
  logic              limite;
  logic              zerado;
`ifdef LAP_CAPTURE_EN
  logic              volta;
  logic [SEC_W-1:0]  volta_seg;
  logic [FRAC_W-1:0] volta_frac;
  logic              volta_valida;
`endif

  modport master (
    output contando, modo_desc, carga, carga_seg, carga_frac,
`ifdef LAP_CAPTURE_EN
    output volta,
    input  volta_seg, volta_frac, volta_valida,
`endif
    input  cont_seg, cont_frac, tick, limite, zerado
  );

  modport slave (
    input  contando, modo_desc, carga, carga_seg, carga_frac,
`ifdef LAP_CAPTURE_EN
    input  volta,
    output volta_seg, volta_frac, volta_valida,
`endif
    output cont_seg, cont_frac, tick, limite, zerado
  );

endinterface

// File: rtl/contador_cronometro_param_divisor_tick.sv
// Prescaler: counts 0..DIV-1 while enabled and flags the last count as a step.
// A pause holds the partial count; clr restarts it from zero.
module divisor_tick #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic passo
);

  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);

  logic [PW-1:0] p_q;
  logic [PW-1:0] p_d;

  always_comb begin
    p_d = p_q;
    if (clr) begin
      p_d = '0;
    end else if (en) begin
      p_d = (p_q == P_LAST) ? '0 : p_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p_q <= '0;
    end else begin
      p_q <= p_d;
    end
  end

  assign passo = en && (p_q == P_LAST);

endmodule

// File: rtl/contador_cronometro_param.sv
// Stopwatch/countdown counter producing seconds.fraction with tick/limite pulses.
// Optional lap snapshot registers are built when LAP_CAPTURE_EN is defined.
module contador_cronometro_param
  import cronometro_pkg::*;
#(
  parameter int CLK_HZ        = CLK_HZ_DEF,
  parameter int TICKS_PER_SEC = TICKS_PER_SEC_DEF,
  parameter int SEC_MAX       = SEC_MAX_DEF,
  parameter int SEC_W         = SEC_W_DEF,
  parameter int FRAC_W        = FRAC_W_DEF
) (
  input logic clk,
  input logic reset,
  contador_cronometro_param_if.slave bus
);

  localparam int DIV = CLK_HZ / TICKS_PER_SEC;
  localparam logic [SEC_W-1:0]  SEC_LAST  = SEC_W'(SEC_MAX);
  localparam logic [FRAC_W-1:0] FRAC_LAST = FRAC_W'(TICKS_PER_SEC - 1);

  logic              passo;
  logic [SEC_W-1:0]  seg_q, seg_d;
  logic [FRAC_W-1:0] frac_q, frac_d;
  logic              tick_q, tick_d;
  logic              limite_q, limite_d;
  logic              zero;

  divisor_tick #(.DIV(DIV)) u_divisor (
    .clk   (clk),
    .reset (reset),
    .en    (bus.contando),
    .clr   (bus.carga),
    .passo (passo)
  );

  assign zero = (seg_q == '0) && (frac_q == '0);

  always_comb begin
    seg_d    = seg_q;
    frac_d   = frac_q;
    tick_d   = 1'b0;
    limite_d = 1'b0;
    if (bus.carga) begin
      seg_d  = (bus.carga_seg  > SEC_LAST)  ? SEC_LAST  : bus.carga_seg;
      frac_d = (bus.carga_frac > FRAC_LAST) ? FRAC_LAST : bus.carga_frac;
    end else if (passo) begin
      if (bus.modo_desc == MODO_CRESC) begin
        tick_d = 1'b1;
        if (frac_q == FRAC_LAST) begin
          frac_d = '0;
          if (seg_q == SEC_LAST) begin
            seg_d    = '0;
            limite_d = 1'b1;
          end else begin
            seg_d = seg_q + SEC_W'(1);
          end
        end else begin
          frac_d = frac_q + FRAC_W'(1);
        end
      end else if (!zero) begin
        // Down mode saturates at 0.0: steps there are silently dropped.
        tick_d   = 1'b1;
        limite_d = (seg_q == '0) && (frac_q == FRAC_W'(1));
        if (frac_q == '0) begin
          frac_d = FRAC_LAST;
          seg_d  = seg_q - SEC_W'(1);
        end else begin
          frac_d = frac_q - FRAC_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seg_q    <= '0;
      frac_q   <= '0;
      tick_q   <= 1'b0;
      limite_q <= 1'b0;
    end else begin
      seg_q    <= seg_d;
      frac_q   <= frac_d;
      tick_q   <= tick_d;
      limite_q <= limite_d;
    end
  end

  assign bus.cont_seg  = seg_q;
  assign bus.cont_frac = frac_q;
  assign bus.tick      = tick_q;
  assign bus.limite    = limite_q;
  assign bus.zerado    = zero;

`ifdef LAP_CAPTURE_EN
  logic [SEC_W-1:0]  volta_seg_q;
  logic [FRAC_W-1:0] volta_frac_q;
  logic              volta_valida_q;

  // Snapshot takes the registered (pre-step) count.
  always_ff @(posedge clk) begin
    if (reset || bus.carga) begin
      volta_seg_q    <= '0;
      volta_frac_q   <= '0;
      volta_valida_q <= 1'b0;
    end else if (bus.volta) begin
      volta_seg_q    <= seg_q;
      volta_frac_q   <= frac_q;
      volta_valida_q <= 1'b1;
    end
  end

  assign bus.volta_seg    = volta_seg_q;
  assign bus.volta_frac   = volta_frac_q;
  assign bus.volta_valida = volta_valida_q;
`endif

endmodule

// File: tb/tb_contador_cronometro_param.sv
// Directed bench for contador_cronometro_param with CLK_HZ=20, TICKS=10, SEC_MAX=3.
// Lap scenario runs only when LAP_CAPTURE_EN is defined.
module tb_contador_cronometro_param;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  contador_cronometro_param_if #(.SEC_W(10), .FRAC_W(4)) bus_if ();

  contador_cronometro_param #(
    .CLK_HZ(20), .TICKS_PER_SEC(10), .SEC_MAX(3), .SEC_W(10), .FRAC_W(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_if.cont_seg !== 10'd0 || bus_if.cont_frac !== 4'd0) begin
      failures++;
      $display("FAIL reset_count got=%0d.%0d exp=0.0", bus_if.cont_seg, bus_if.cont_frac);
    end
    checks++;
    if (bus_if.tick !== 1'b0 || bus_if.limite !== 1'b0 || bus_if.zerado !== 1'b1) begin
      failures++;
      $display("FAIL reset_flags got tick=%b limite=%b zerado=%b exp 0 0 1",
               bus_if.tick, bus_if.limite, bus_if.zerado);
    end
`ifdef LAP_CAPTURE_EN
    checks++;
    if (bus_if.volta_valida !== 1'b0) begin
      failures++;
      $display("FAIL reset_lap got=%b exp=0", bus_if.volta_valida);
    end
`endif
  endtask

  task automatic test_up_wrap();
    int es = 0;
    int ef = 0;
    logic et;
    logic el;
    int pulses = 0;
    bus_if.modo_desc = 1'b0;
    bus_if.contando  = 1'b1;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      et = 1'b0;
      el = 1'b0;
      if (i % 2 == 0) begin
        et = 1'b1;
        if (ef == 9) begin
          ef = 0;
          if (es == 3) begin es = 0; el = 1'b1; end
          else es++;
        end else begin
          ef++;
        end
      end
      if (bus_if.limite === 1'b1) pulses++;
      checks++;
      if (bus_if.cont_seg !== 10'(es) || bus_if.cont_frac !== 4'(ef) ||
          bus_if.tick !== et || bus_if.limite !== el || bus_if.zerado !== (es == 0 && ef == 0)) begin
        failures++;
        $display("FAIL up_cycle%0d got=%0d.%0d t=%b l=%b z=%b exp=%0d.%0d t=%b l=%b",
                 i, bus_if.cont_seg, bus_if.cont_frac, bus_if.tick, bus_if.limite,
                 bus_if.zerado, es, ef, et, el);
      end
    end
    checks++;
    if (pulses != 1) begin
      failures++;
      $display("FAIL up_limite_pulses got=%0d exp=1", pulses);
    end
    bus_if.contando = 1'b0;
  endtask

  task automatic test_down_zero();
    int es = 1;
    int ef = 2;
    logic et;
    logic el;
    int pulses = 0;
    int ticks = 0;
    bus_if.modo_desc  = 1'b1;
    bus_if.carga      = 1'b1;
    bus_if.carga_seg  = 10'd1;
    bus_if.carga_frac = 4'd2;
    @(negedge clk);
    bus_if.carga = 1'b0;
    checks++;
    if (bus_if.cont_seg !== 10'd1 || bus_if.cont_frac !== 4'd2 || bus_if.tick !== 1'b0) begin
      failures++;
      $display("FAIL down_load got=%0d.%0d t=%b exp=1.2 t=0",
               bus_if.cont_seg, bus_if.cont_frac, bus_if.tick);
    end
    bus_if.contando = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      et = 1'b0;
      el = 1'b0;
      if (i % 2 == 0 && !(es == 0 && ef == 0)) begin
        et = 1'b1;
        if (ef == 0) begin ef = 9; es--; end
        else ef--;
        el = (es == 0 && ef == 0);
      end
      if (bus_if.limite === 1'b1) pulses++;
      if (bus_if.tick === 1'b1) ticks++;
      checks++;
      if (bus_if.cont_seg !== 10'(es) || bus_if.cont_frac !== 4'(ef) ||
          bus_if.tick !== et || bus_if.limite !== el) begin
        failures++;
        $display("FAIL down_cycle%0d got=%0d.%0d t=%b l=%b exp=%0d.%0d t=%b l=%b",
                 i, bus_if.cont_seg, bus_if.cont_frac, bus_if.tick, bus_if.limite,
                 es, ef, et, el);
      end
    end
    checks++;
    if (pulses != 1 || ticks != 12 || bus_if.zerado !== 1'b1) begin
      failures++;
      $display("FAIL down_summary got pulses=%0d ticks=%0d zerado=%b exp 1 12 1",
               pulses, ticks, bus_if.zerado);
    end
    bus_if.contando = 1'b0;
  endtask

  task automatic test_pause();
    bus_if.modo_desc  = 1'b0;
    bus_if.carga      = 1'b1;
    bus_if.carga_seg  = 10'd0;
    bus_if.carga_frac = 4'd0;
    @(negedge clk);
    bus_if.carga    = 1'b0;
    bus_if.contando = 1'b1;
    @(negedge clk);
    checks++;
    if (bus_if.cont_frac !== 4'd0 || bus_if.tick !== 1'b0) begin
      failures++;
      $display("FAIL pause_prestep got=%0d t=%b exp=0 t=0", bus_if.cont_frac, bus_if.tick);
    end
    bus_if.contando = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      checks++;
      if (bus_if.cont_seg !== 10'd0 || bus_if.cont_frac !== 4'd0 || bus_if.tick !== 1'b0) begin
        failures++;
        $display("FAIL pause_hold%0d got=%0d.%0d t=%b exp=0.0 t=0",
                 i, bus_if.cont_seg, bus_if.cont_frac, bus_if.tick);
      end
    end
    bus_if.contando = 1'b1;
    @(negedge clk);
    checks++;
    if (bus_if.cont_seg !== 10'd0 || bus_if.cont_frac !== 4'd1 || bus_if.tick !== 1'b1) begin
      failures++;
      $display("FAIL pause_resume got=%0d.%0d t=%b exp=0.1 t=1",
               bus_if.cont_seg, bus_if.cont_frac, bus_if.tick);
    end
  endtask

  task automatic test_load_clamp();
    @(negedge clk);
    checks++;
    if (bus_if.cont_frac !== 4'd1 || bus_if.tick !== 1'b0) begin
      failures++;
      $display("FAIL clamp_prestep got=%0d t=%b exp=1 t=0", bus_if.cont_frac, bus_if.tick);
    end
    bus_if.carga      = 1'b1;
    bus_if.carga_seg  = 10'd9;
    bus_if.carga_frac = 4'd15;
    @(negedge clk);
    bus_if.carga = 1'b0;
    checks++;
    if (bus_if.cont_seg !== 10'd3 || bus_if.cont_frac !== 4'd9 ||
        bus_if.tick !== 1'b0 || bus_if.limite !== 1'b0 || bus_if.zerado !== 1'b0) begin
      failures++;
      $display("FAIL clamp_load got=%0d.%0d t=%b l=%b z=%b exp=3.9 t=0 l=0 z=0",
               bus_if.cont_seg, bus_if.cont_frac, bus_if.tick, bus_if.limite, bus_if.zerado);
    end
  endtask

  task automatic test_reset_on_wrap();
    @(negedge clk);
    checks++;
    if (bus_if.cont_seg !== 10'd3 || bus_if.cont_frac !== 4'd9) begin
      failures++;
      $display("FAIL rwrap_prestep got=%0d.%0d exp=3.9", bus_if.cont_seg, bus_if.cont_frac);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (bus_if.cont_seg !== 10'd0 || bus_if.cont_frac !== 4'd0 ||
        bus_if.tick !== 1'b0 || bus_if.limite !== 1'b0 || bus_if.zerado !== 1'b1) begin
      failures++;
      $display("FAIL rwrap_reset got=%0d.%0d t=%b l=%b z=%b exp=0.0 t=0 l=0 z=1",
               bus_if.cont_seg, bus_if.cont_frac, bus_if.tick, bus_if.limite, bus_if.zerado);
    end
    @(negedge clk);
    checks++;
    if (bus_if.tick !== 1'b0 || bus_if.limite !== 1'b0 || bus_if.cont_frac !== 4'd0) begin
      failures++;
      $display("FAIL rwrap_after got=%0d t=%b l=%b exp=0 t=0 l=0",
               bus_if.cont_frac, bus_if.tick, bus_if.limite);
    end
    bus_if.contando = 1'b0;
  endtask

`ifdef LAP_CAPTURE_EN
  task automatic test_lap();
    bus_if.modo_desc  = 1'b0;
    bus_if.carga      = 1'b1;
    bus_if.carga_seg  = 10'd2;
    bus_if.carga_frac = 4'd5;
    @(negedge clk);
    bus_if.carga    = 1'b0;
    bus_if.contando = 1'b1;
    @(negedge clk);
    bus_if.volta = 1'b1;
    @(negedge clk);
    bus_if.volta = 1'b0;
    checks++;
    if (bus_if.volta_seg !== 10'd2 || bus_if.volta_frac !== 4'd5 ||
        bus_if.volta_valida !== 1'b1 || bus_if.cont_frac !== 4'd6) begin
      failures++;
      $display("FAIL lap_capture got=%0d.%0d v=%b cont_frac=%0d exp=2.5 v=1 cont_frac=6",
               bus_if.volta_seg, bus_if.volta_frac, bus_if.volta_valida, bus_if.cont_frac);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (bus_if.cont_frac !== 4'd8 || bus_if.volta_frac !== 4'd5 || bus_if.volta_valida !== 1'b1) begin
      failures++;
      $display("FAIL lap_persist got cont_frac=%0d lap=%0d v=%b exp 8 5 1",
               bus_if.cont_frac, bus_if.volta_frac, bus_if.volta_valida);
    end
    bus_if.carga      = 1'b1;
    bus_if.carga_seg  = 10'd0;
    bus_if.carga_frac = 4'd0;
    @(negedge clk);
    bus_if.carga = 1'b0;
    checks++;
    if (bus_if.volta_valida !== 1'b0) begin
      failures++;
      $display("FAIL lap_clear got=%b exp=0", bus_if.volta_valida);
    end
    bus_if.contando = 1'b0;
  endtask
`endif

  initial begin
    checks            = 0;
    failures          = 0;
    reset             = 1'b1;
    bus_if.contando   = 1'b0;
    bus_if.modo_desc  = 1'b0;
    bus_if.carga      = 1'b0;
    bus_if.carga_seg  = '0;
    bus_if.carga_frac = '0;
`ifdef LAP_CAPTURE_EN
    bus_if.volta      = 1'b0;
`endif
    test_reset();
    test_up_wrap();
    test_down_zero();
    test_pause();
    test_load_clamp();
    test_reset_on_wrap();
`ifdef LAP_CAPTURE_EN
    test_lap();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
